csi_raw10_unpack: RTL and testbench

- Downstream of the CSI-2 receiver top, in the `word_clk` domain.
- Consumes the 32-bit packed payload stream (`payload_data`/`payload_enable`/`payload_frame`) plus `vsync`.
- Unpacks MIPI RAW10 (DT 0x2B): every 5 payload bytes become 4 10-bit pixels.
- Emits one 4-pixel group per cycle, with line/frame markers and x/y position counters for the downstream framebuffer or ISP.

---
 rtl/csi_raw10_unpack.sv | 166 ++++++++++++++++
 tb/tb_csi_raw10_unpack.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_raw10_unpack.sv
// RAW10 unpacker: turns the 32-bit packed CSI-2 payload stream into 4-pixel groups
// with line/frame start markers, group index and line/frame counters.
module csi_raw10_unpack #(
    parameter int X_BITS     = 12,
    parameter int Y_BITS     = 12,
    parameter int FRAME_BITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [31:0]           payload_data,
    input  logic                  payload_enable,
    input  logic                  payload_frame,
    input  logic                  vsync,
    output logic [39:0]           pix_data,
    output logic                  pix_valid,
    output logic                  pix_line_start,
    output logic                  pix_frame_start,
    output logic [X_BITS-1:0]     pix_x,
    output logic [Y_BITS-1:0]     line_count,
    output logic [FRAME_BITS-1:0] frame_count,
    output logic                  err_partial
);

    logic [63:0]           r_buf;
    logic [3:0]            r_bcnt;
    logic                  r_frame_prev;
    logic                  r_seen_low;
    logic                  r_line_pend;
    logic                  r_frame_pend;
    logic                  r_line_has_group;
    logic [39:0]           r_pix_data;
    logic                  r_pix_valid;
    logic                  r_line_start;
    logic                  r_frame_start;
    logic                  r_err_partial;
    logic [X_BITS-1:0]     r_pix_x;
    logic [X_BITS-1:0]     r_x_next;
    logic [Y_BITS-1:0]     r_line_count;
    logic [FRAME_BITS-1:0] r_frame_count;

    logic                  w_accept;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_vsync;
    logic                  w_emit;
    logic [6:0]            w_shamt;
    logic [63:0]           w_buf_app;
    logic [3:0]            w_cnt_app;
    logic [39:0]           w_group;
    logic [X_BITS-1:0]     w_x_cur;

    // A rising payload_frame only counts once a low level has been seen since reset,
    // so a line that is already running when reset releases gets no line start.
    always_comb begin
        w_accept  = enable && payload_frame && payload_enable;
        w_rise    = enable && payload_frame && !r_frame_prev && r_seen_low;
        w_fall    = enable && !payload_frame && r_frame_prev;
        w_vsync   = enable && vsync;
        w_shamt   = {r_bcnt, 3'b000};
        w_buf_app = r_buf;
        w_cnt_app = r_bcnt;
        if (w_accept) begin
            w_buf_app = r_buf | ({32'd0, payload_data} << w_shamt);
            w_cnt_app = r_bcnt + 4'd4;
        end
        w_emit  = enable && (w_cnt_app >= 4'd5);
        w_group = '0;
        for (int n = 0; n < 4; n++) begin
            w_group[10*n +: 10] = {w_buf_app[8*n +: 8], w_buf_app[32 + 2*n +: 2]};
        end
        w_x_cur = w_rise ? '0 : r_x_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_buf            <= '0;
            r_bcnt           <= '0;
            r_frame_prev     <= 1'b0;
            r_seen_low       <= 1'b0;
            r_line_pend      <= 1'b0;
            r_frame_pend     <= 1'b0;
            r_line_has_group <= 1'b0;
            r_pix_data       <= '0;
            r_pix_valid      <= 1'b0;
            r_line_start     <= 1'b0;
            r_frame_start    <= 1'b0;
            r_err_partial    <= 1'b0;
            r_pix_x          <= '0;
            r_x_next         <= '0;
            r_line_count     <= '0;
            r_frame_count    <= '0;
        end else if (enable) begin
            r_frame_prev <= payload_frame;
            if (!payload_frame) begin
                r_seen_low <= 1'b1;
            end

            r_pix_valid   <= w_emit;
            r_line_start  <= w_emit && (r_line_pend || w_rise);
            r_frame_start <= w_emit && (r_frame_pend || w_vsync);
            r_err_partial <= w_fall && (r_bcnt != 4'd0);

            if (w_emit) begin
                r_pix_data <= w_group;
                r_pix_x    <= w_x_cur;
                r_x_next   <= (&w_x_cur) ? w_x_cur : w_x_cur + 1'b1;
            end else if (w_rise) begin
                r_x_next <= '0;
            end

            // Leftover bytes at line end are dropped, never carried to the next line.
            if (w_fall) begin
                r_buf  <= '0;
                r_bcnt <= '0;
            end else if (w_emit) begin
                r_buf  <= w_buf_app >> 40;
                r_bcnt <= w_cnt_app - 4'd5;
            end else begin
                r_buf  <= w_buf_app;
                r_bcnt <= w_cnt_app;
            end

            if (w_emit) begin
                r_line_pend <= 1'b0;
            end else if (w_rise) begin
                r_line_pend <= 1'b1;
            end

            if (w_emit) begin
                r_frame_pend <= 1'b0;
            end else if (w_vsync) begin
                r_frame_pend <= 1'b1;
            end

            if (w_emit) begin
                r_line_has_group <= 1'b1;
            end else if (w_rise || w_fall) begin
                r_line_has_group <= 1'b0;
            end

            // vsync wins over a coincident line end, leaving the count at zero.
            if (w_vsync) begin
                r_line_count <= '0;
            end else if (w_fall && r_line_has_group && !(&r_line_count)) begin
                r_line_count <= r_line_count + 1'b1;
            end

            if (w_vsync) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
        end
    end

    // Pulses are held while stalled and only shown once enable returns, so no
    // group is lost and nothing pulses during a stall.
    assign pix_valid       = r_pix_valid && enable;
    assign pix_line_start  = r_line_start && enable;
    assign pix_frame_start = r_frame_start && enable;
    assign err_partial     = r_err_partial && enable;
    assign pix_data        = r_pix_data;
    assign pix_x           = r_pix_x;
    assign line_count      = r_line_count;
    assign frame_count     = r_frame_count;

endmodule

// File: tb/tb_csi_raw10_unpack.sv
// Scoreboard bench for csi_raw10_unpack: a byte-queue reference model predicts each
// pixel group; a negedge monitor compares every presented group and error pulse.
module tb_csi_raw10_unpack;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] payload_data;
    logic        payload_enable;
    logic        payload_frame;
    logic        vsync;
    logic [39:0] pix_data;
    logic        pix_valid;
    logic        pix_line_start;
    logic        pix_frame_start;
    logic [11:0] pix_x;
    logic [11:0] line_count;
    logic [7:0]  frame_count;
    logic        err_partial;

    csi_raw10_unpack #(.X_BITS(12), .Y_BITS(12), .FRAME_BITS(8)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .payload_data(payload_data), .payload_enable(payload_enable),
        .payload_frame(payload_frame), .vsync(vsync),
        .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_line_start(pix_line_start), .pix_frame_start(pix_frame_start),
        .pix_x(pix_x), .line_count(line_count), .frame_count(frame_count),
        .err_partial(err_partial)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [39:0] data;
        logic [11:0] x;
        logic        ls;
        logic        fs;
        logic [11:0] lc;
        logic [7:0]  fc;
    } grp_t;

    grp_t       sb[$];
    logic [7:0] line_bytes[$];
    int         total = 0;
    int         bad = 0;
    int         err_pending = 0;
    bit         m_line_pend, m_frame_pend, m_has_group;
    int         m_x, m_lc, m_fc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_push_word(input logic [31:0] w);
        int   b[5];
        grp_t g;
        for (int i = 0; i < 4; i++) line_bytes.push_back(w[8*i +: 8]);
        if (line_bytes.size() >= 5) begin
            for (int i = 0; i < 5; i++) b[i] = int'(line_bytes.pop_front());
            g.data = '0;
            for (int n = 0; n < 4; n++) begin
                g.data = g.data | (40'(b[n] * 4 + ((b[4] >> (2 * n)) % 4)) << (10 * n));
            end
            g.x  = 12'(m_x);
            g.ls = m_line_pend;
            g.fs = m_frame_pend;
            g.lc = 12'(m_lc);
            g.fc = 8'(m_fc);
            sb.push_back(g);
            m_line_pend  = 0;
            m_frame_pend = 0;
            m_has_group  = 1;
            if (m_x < 4095) m_x++;
        end
    endtask

    task automatic model_reset();
        line_bytes.delete();
        m_line_pend = 0; m_frame_pend = 0; m_has_group = 0;
        m_x = 0; m_lc = 0; m_fc = 0;
    endtask

    task automatic model_vsync();
        m_lc = 0;
        m_fc = (m_fc + 1) % 256;
        m_frame_pend = 1;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit en, input bit fr, input bit pe, input logic [31:0] d, input bit vs);
        enable = en; payload_frame = fr; payload_enable = pe; payload_data = d; vsync = vs;
        if (en && fr && pe) model_push_word(d);
        cyc();
    endtask

    task automatic send_word(input logic [31:0] d);
        drive(1, 1, 1, d, 0);
    endtask

    task automatic line_begin();
        m_line_pend = 1; m_x = 0; m_has_group = 0;
    endtask

    task automatic line_end(input bit with_vsync);
        if (line_bytes.size() != 0) err_pending++;
        line_bytes.delete();
        if (m_has_group && m_lc < 4095) m_lc++;
        if (with_vsync) model_vsync();
        drive(1, 0, 0, $urandom, with_vsync);
    endtask

    task automatic do_vsync();
        model_vsync();
        drive(1, 0, 0, 32'd0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 32'd0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pix_data"},    64'(pix_data), 64'd0);
        chk({tag, "_pix_valid"},   64'(pix_valid), 64'd0);
        chk({tag, "_pix_x"},       64'(pix_x), 64'd0);
        chk({tag, "_line_count"},  64'(line_count), 64'd0);
        chk({tag, "_frame_count"}, 64'(frame_count), 64'd0);
        chk({tag, "_err_partial"}, 64'(err_partial), 64'd0);
    endtask

    always @(negedge clock) begin
        grp_t g;
        if (enable === 1'b0) begin
            total++;
            if (pix_valid || pix_line_start || pix_frame_start || err_partial) begin
                bad++;
                $display("FAIL stall_pulse: got valid=%0b ls=%0b fs=%0b err=%0b expected all 0",
                         pix_valid, pix_line_start, pix_frame_start, err_partial);
            end
        end
        if (pix_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_group: got data=%0h with no group expected", pix_data);
            end else begin
                g = sb.pop_front();
                if ({pix_data, pix_x, pix_line_start, pix_frame_start, line_count, frame_count} !==
                    {g.data, g.x, g.ls, g.fs, g.lc, g.fc}) begin
                    bad++;
                    $display("FAIL group: got data=%0h x=%0d ls=%0b fs=%0b lc=%0d fc=%0d expected data=%0h x=%0d ls=%0b fs=%0b lc=%0d fc=%0d",
                             pix_data, pix_x, pix_line_start, pix_frame_start, line_count, frame_count,
                             g.data, g.x, g.ls, g.fs, g.lc, g.fc);
                end
            end
        end
        if (err_partial === 1'b1) begin
            total++;
            if (err_pending == 0) begin
                bad++;
                $display("FAIL err_partial: got pulse expected none");
            end else begin
                err_pending--;
            end
        end
    end

    initial begin
        int nw;
        reset = 1'b1; enable = 1'b1; payload_data = '0;
        payload_enable = 1'b0; payload_frame = 1'b0; vsync = 1'b0;
        model_reset();
        idle(3);
        reset = 1'b0;
        check_all_zero("reset");
        idle(2);

        // directed line with known bytes 00..13
        do_vsync();
        line_begin();
        for (int k = 0; k < 5; k++) begin
            send_word({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
            if (k == 1) begin
                chk("g0_data", 64'(pix_data), 64'h00_0300_801400);
                chk("g0_line_start", 64'(pix_line_start), 64'd1);
                chk("g0_frame_start", 64'(pix_frame_start), 64'd1);
            end
        end
        line_end(0);
        chk("line_count_1", 64'(line_count), 64'd1);
        idle(2);

        // partial line then clean line
        line_begin();
        send_word($urandom); send_word($urandom);
        line_end(0);
        chk("partial_err", 64'(err_partial), 64'd1);
        idle(1);
        line_begin();
        for (int k = 0; k < 5; k++) send_word($urandom);
        line_end(0);
        idle(2);

        // gapped and stalled lines
        for (int l = 0; l < 6; l++) begin
            line_begin();
            nw = $urandom_range(1, 12);
            for (int k = 0; k < nw; k++) begin
                while ($urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 0) drive(1, 1, 0, $urandom, 0);
                    else drive(0, 1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
                end
                send_word($urandom);
            end
            line_end(0);
            idle($urandom_range(1, 3));
        end

        // frame counters and wrap
        do_vsync();
        for (int l = 0; l < 3; l++) begin
            line_begin();
            for (int k = 0; k < 5; k++) send_word($urandom);
            line_end(0);
            idle(1);
        end
        chk("line_count_3", 64'(line_count), 64'd3);
        do_vsync();
        chk("line_count_after_vsync", 64'(line_count), 64'd0);
        chk("frame_count_inc", 64'(frame_count), 64'(m_fc));
        while (m_fc != 255) do_vsync();
        chk("frame_count_ff", 64'(frame_count), 64'hFF);
        do_vsync();
        chk("frame_count_wrap", 64'(frame_count), 64'h00);
        idle(1);

        // vsync coincident with a line end that has leftovers
        line_begin();
        for (int k = 0; k < 3; k++) send_word($urandom);
        line_end(1);
        chk("vsync_line_end_count", 64'(line_count), 64'd0);
        chk("vsync_line_end_err", 64'(err_partial), 64'd1);
        idle(2);

        // reset in the middle of a line
        line_begin();
        for (int k = 0; k < 3; k++) send_word($urandom);
        drive(1, 1, 0, 32'd0, 0);
        drive(1, 1, 0, 32'd0, 0);
        chk("sb_empty_before_reset", 64'(sb.size()), 64'd0);
        reset = 1'b1;
        drive(1, 1, 0, 32'd0, 0);
        reset = 1'b0;
        model_reset();
        check_all_zero("midreset");
        for (int k = 0; k < 5; k++) send_word($urandom);
        line_end(0);
        chk("post_reset_line_count", 64'(line_count), 64'd1);
        idle(1);
        line_begin();
        for (int k = 0; k < 5; k++) send_word($urandom);
        line_end(0);
        idle(4);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        chk("err_all_seen", 64'(err_pending), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
